// File: rtl/request_encoder_pkg.sv
// Shared definitions for the request encoder: FSM state encoding.
package request_encoder_pkg;

    localparam logic RE_IDLE = 1'b0;
    localparam logic RE_BUSY = 1'b1;

    typedef enum logic {
        IDLE = RE_IDLE,
        BUSY = RE_BUSY
    } re_state_t;

endpackage

// File: rtl/request_encoder_if.sv
// Request/grant bus between request sources, the encoder and the index consumer.
interface request_encoder_if #(parameter int n = 4);

    logic [2**n-1:0] req;
    logic            enable;
    logic            ack;
    logic            valid;
    logic [n-1:0]    index;
    logic [2**n-1:0] pending;

    modport master (
        output req, enable, ack,
        input  valid, index, pending
    );

    modport slave (
        input  req, enable, ack,
        output valid, index, pending
    );

endinterface

// File: rtl/request_encoder_priority_encoder.sv
// Combinational lowest-set-bit encoder: out is the index of the lowest set bit of in.
module priority_encoder #(
    parameter int n = 4
) (
    input  logic [2**n-1:0] in,
    output logic [n-1:0]    out,
    output logic            found
);

    always_comb begin
        out = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = 2**n - 1; i >= 0; i--) begin
            if (in[i]) out = n'(i);
        end
    end

    assign found = |in;

endmodule

// File: rtl/request_encoder.sv
// Collects request pulses into a pending register and issues them one at a time,
// lowest index first, as a binary index held under a valid/ack handshake.
module request_encoder
    import request_encoder_pkg::*;
#(
    parameter int n = 4
) (
    input  logic              clk,
    input  logic              reset,
    request_encoder_if.slave  bus
);

    re_state_t       state, state_next;
    logic [2**n-1:0] pending_q;
    logic [n-1:0]    index_q;
    logic            valid_q;
    logic [n-1:0]    enc_out;
    logic            enc_found;
    logic            grant;
    logic            done;
    logic [2**n-1:0] clr;

    function automatic logic [2**n-1:0] onehot(input logic [n-1:0] idx);
        logic [2**n-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // The encoder sees only the registered pending bits, never req directly.
    priority_encoder #(.n(n)) u_penc (
        .in    (pending_q),
        .out   (enc_out),
        .found (enc_found)
    );

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable && enc_found) begin
                    state_next = BUSY;
                    grant      = 1'b1;
                end
            end
            BUSY: begin
                if (bus.ack) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign clr = done ? onehot(index_q) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending_q <= '0;
            valid_q   <= 1'b0;
            index_q   <= '0;
        end else begin
            state     <= state_next;
            // New requests are ORed in after the clear, so a re-request survives its ack.
            pending_q <= (pending_q & ~clr) | bus.req;
            if (grant) begin
                index_q <= enc_out;
                valid_q <= 1'b1;
            end else if (done) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.valid   = valid_q;
    assign bus.index   = index_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_request_encoder.sv
// Directed test of request_encoder with a grant scoreboard checked by an independent monitor.
module tb_request_encoder;

    localparam int N = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   exp_q[$];

    request_encoder_if #(.n(N)) bus ();

    request_encoder #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        @(negedge clk);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req_v);
        end
    endtask

    task automatic chk_state(input string name, input logic v, input logic [N-1:0] idx,
                             input logic [2**N-1:0] pend);
        @(negedge clk);
        total++;
        if (bus.valid !== v || bus.index !== idx || bus.pending !== pend) begin
            bad++;
            $display("FAIL %s: got valid=%0b index=%0d pending=%04h expected valid=%0b index=%0d pending=%04h",
                     name, bus.valid, bus.index, bus.pending, v, idx, pend);
        end
    endtask

    // Monitor: every rising edge of valid is a grant; compare it with the oldest expectation.
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.valid === 1'b1 && prev_valid !== 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL grant: got unexpected index %0d expected none", bus.index);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(bus.index) != e) begin
                        bad++;
                        $display("FAIL grant: got index %0d expected %0d", bus.index, e);
                    end
                end
            end
            prev_valid = bus.valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        bus.req    = 16'hFFFF;
        bus.enable = 1'b1;
        bus.ack    = 1'b0;

        // Reset held two cycles with all requests asserted.
        tick();
        tick();
        reset   = 1'b0;
        bus.req = '0;
        tick();
        chk_state("reset", 1'b0, 4'd0, 16'h0000);

        // Ordering: 0x0028 -> index 3, then 5.
        exp_q.push_back(3);
        exp_q.push_back(5);
        bus.req = 16'h0028;
        tick();
        bus.req = '0;
        check("pend_after_req", 32'(bus.pending), 32'h0028);
        check("valid_latency", 32'(bus.valid), 32'h0);
        tick();
        chk_state("order_first", 1'b1, 4'd3, 16'h0028);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk_state("order_ack1", 1'b0, 4'd3, 16'h0020);
        tick();
        chk_state("order_second", 1'b1, 4'd5, 16'h0020);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk_state("order_ack2", 1'b0, 4'd5, 16'h0000);

        // Set wins over clear.
        exp_q.push_back(3);
        exp_q.push_back(3);
        bus.req = 16'h0008;
        tick();
        bus.req = '0;
        tick();
        chk_state("setwin_busy", 1'b1, 4'd3, 16'h0008);
        bus.ack = 1'b1;
        bus.req = 16'h0008;
        tick();
        bus.ack = 1'b0;
        bus.req = '0;
        chk_state("setwin_keep", 1'b0, 4'd3, 16'h0008);
        tick();
        chk_state("setwin_regrant", 1'b1, 4'd3, 16'h0008);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk_state("setwin_done", 1'b0, 4'd3, 16'h0000);

        // Enable gating and top index.
        bus.enable = 1'b0;
        bus.req    = 16'h8000;
        tick();
        bus.req = '0;
        for (int i = 0; i < 10; i++) begin
            check("gated_valid", 32'(bus.valid), 32'h0);
            tick();
        end
        check("gated_pending", 32'(bus.pending), 32'h8000);
        exp_q.push_back(15);
        bus.enable = 1'b1;
        tick();
        chk_state("top_bit", 1'b1, 4'd15, 16'h8000);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk_state("top_done", 1'b0, 4'd15, 16'h0000);

        // Preemption: lower index arriving while busy goes ahead of older 12.
        exp_q.push_back(9);
        exp_q.push_back(2);
        exp_q.push_back(12);
        bus.req = 16'h1200;
        tick();
        bus.req = '0;
        tick();
        chk_state("pre_busy9", 1'b1, 4'd9, 16'h1200);
        bus.req = 16'h0004;
        tick();
        bus.req = '0;
        chk_state("pre_hold9", 1'b1, 4'd9, 16'h1204);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        chk_state("pre_grant2", 1'b1, 4'd2, 16'h1004);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        chk_state("pre_grant12", 1'b1, 4'd12, 16'h1000);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;

        // Reset in the middle of a handshake.
        exp_q.push_back(7);
        bus.req = 16'h0180;
        tick();
        bus.req = '0;
        tick();
        chk_state("mid_busy7", 1'b1, 4'd7, 16'h0180);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_state("mid_reset", 1'b0, 4'd0, 16'h0000);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk_state("idle_ack", 1'b0, 4'd0, 16'h0000);
        tick();
        tick();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL grants_left: got %0d outstanding expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
